prog_loader: RTL and testbench

Boot-time instruction-memory loader that sits directly upstream of the single-cycle core. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory. It holds the core in reset (`core_reset`, wired to the core's `reset_s`) until the last word has been written, then releases it.

---
 rtl/prog_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction-memory loader.
// Takes a length-prefixed byte stream (16-bit word count, then 4*N bytes,
// little-endian words). It writes each assembled word into instruction
// memory and keeps the core in reset until the final write has been issued.
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_s,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        core_reset,
  output logic        done,
  output logic        err
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  // DEPTH kept at 17 bits so that a full 2^16-word memory is still representable.
  localparam logic [16:0]      DEPTH_W = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_WORD   = 3'd3,
    S_FLUSH  = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  // One extra bit so a load of exactly DEPTH words never wraps the index.
  logic [ADDR_W:0]   r_widx;
  logic [1:0]        r_bidx;
  // Holds bytes 0..2 of the word in flight; byte 3 comes straight off the bus.
  logic [23:0]       r_asm;
  logic [CNT_W-1:0]  r_to_cnt;

  logic              w_xfer;
  logic              w_to_hit;
  logic              w_len_bad;
  logic              w_last_word;
  logic              w_word_end;
  logic [15:0]       w_len_in;

  // byte_ready decoded directly from the state: only the three stream-consuming states accept.
  always_comb begin
    byte_ready = 1'b0;
    case (r_state)
      S_LEN_LO: byte_ready = 1'b1;
      S_LEN_HI: byte_ready = 1'b1;
      S_WORD:   byte_ready = 1'b1;
      default:  byte_ready = 1'b0;
    endcase
  end

  assign w_xfer      = byte_valid & byte_ready;
  assign w_len_in    = {byte_data, r_len_lo};
  assign w_len_bad   = (w_len_in == 16'd0) || ({1'b0, w_len_in} > DEPTH_W);
  assign w_word_end  = (r_bidx == 2'd3);
  assign w_last_word = (({{(16 - ADDR_W){1'b0}}, r_widx} + 17'd1) == {1'b0, r_len});
  // The stall limit is reached on the TIMEOUT-th consecutive idle cycle.
  assign w_to_hit    = byte_ready && !w_xfer && (r_to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset_s) begin
    if (reset_s) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: stream parsing, length validation, stall timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LEN_LO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          w_state_nxt = S_LEN_HI;
        end else if (w_to_hit) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          if (w_len_bad) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_WORD;
          end
        end else if (w_to_hit) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_LEN_HI;
        end
      end
      S_WORD: begin
        if (w_xfer) begin
          if (w_word_end && w_last_word) begin
            w_state_nxt = S_FLUSH;
          end else begin
            w_state_nxt = S_WORD;
          end
        end else if (w_to_hit) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_WORD;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          w_state_nxt = S_LEN_LO;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_ERR: begin
        if (start) begin
          w_state_nxt = S_LEN_LO;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs: word assembly, write strobe, core reset, status flags.
  always_ff @(posedge clk or posedge reset_s) begin
    if (reset_s) begin
      r_len_lo     <= 8'd0;
      r_len        <= 16'd0;
      r_widx       <= '0;
      r_bidx       <= 2'd0;
      r_asm        <= 24'd0;
      r_to_cnt     <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= 32'd0;
      imem_wr_data <= 32'd0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_wr_en <= 1'b0;

      // Idle-cycle counter; idle outside the accepting states, restarts on every byte.
      if (!byte_ready || w_xfer) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end

      case (r_state)
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len_lo <= byte_data;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len  <= w_len_in;
            r_widx <= '0;
            r_bidx <= 2'd0;
          end
        end
        S_WORD: begin
          if (w_xfer) begin
            r_asm  <= {byte_data, r_asm[23:8]};
            r_bidx <= r_bidx + 2'd1;
            if (w_word_end) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= {{(32 - ADDR_W){1'b0}}, r_widx[ADDR_W-1:0]};
              imem_wr_data <= {byte_data, r_asm};
              r_widx       <= r_widx + (ADDR_W + 1)'(1);
            end
          end
        end
        S_FLUSH: begin
          // Final write was strobed in this cycle; release the core on the next edge.
          core_reset <= 1'b0;
          done       <= 1'b1;
        end
        S_RUN: begin
          if (start) begin
            core_reset <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_ERR: begin
          if (start) begin
            err <= 1'b0;
          end
        end
        default: begin
        end
      endcase

      if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of load scenarios with random payloads
// checked against a byte-stream model, plus hand-written timeout,
// restart-from-RUN and mid-load reset sequences.
module tb_prog_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1024;
  localparam int NV      = 8;

  logic        clk;
  logic        reset_s;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        core_reset;
  logic        done;
  logic        err;

  int tests;
  int fails;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] prev_data[$];
  logic [7:0]  payload[$];

  typedef struct {
    logic [15:0] len;
    logic        fixed;
    logic        reuse;
    int          gap_max;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs[NV];

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_s(reset_s), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .core_reset(core_reset), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe cycle.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      cap_addr.push_back(imem_wr_addr);
      cap_data.push_back(imem_wr_data);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; returns right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, byte_ready}, 32'd1);
    tick();
  endtask

  // Reference: word i of the payload, little-endian.
  function automatic logic [31:0] model_word(input int i);
    return {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
  endfunction

  task automatic check_words(input string name, input int n);
    int nbad;
    nbad = 0;
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      if (cap_data[i] !== model_word(i) || cap_addr[i] !== 32'(i)) nbad++;
    end
    chk(name, 32'(nbad), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int gap;
    pulse_start();
    chk($sformatf("v%0d_start_ready", idx), {31'd0, byte_ready}, 32'd1);
    chk($sformatf("v%0d_start_corerst", idx), {31'd0, core_reset}, 32'd1);
    chk($sformatf("v%0d_start_err", idx), {31'd0, err}, 32'd0);
    cap_addr.delete();
    cap_data.delete();
    if (v.fixed) begin
      payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    end else if (!v.reuse) begin
      payload.delete();
      for (int i = 0; i < 4 * v.exp_writes; i++) payload.push_back(8'($urandom_range(0, 255)));
    end
    send_byte(v.len[7:0], 0);
    send_byte(v.len[15:8], 0);
    for (int i = 0; i < 4 * v.exp_writes; i++) begin
      gap = (v.gap_max > 0) ? int'($urandom_range(0, v.gap_max)) : 0;
      send_byte(payload[i], gap);
    end
    byte_valid = 1'b0;
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", idx), {31'd0, err}, 32'd1);
      chk($sformatf("v%0d_err_corerst", idx), {31'd0, core_reset}, 32'd1);
      chk($sformatf("v%0d_err_ready", idx), {31'd0, byte_ready}, 32'd0);
      chk($sformatf("v%0d_err_done", idx), {31'd0, done}, 32'd0);
      tick();
    end else begin
      // Just after the edge that took the last byte: strobe up, core still held, FLUSH.
      chk($sformatf("v%0d_last_wren", idx), {31'd0, imem_wr_en}, 32'd1);
      chk($sformatf("v%0d_flush_corerst", idx), {31'd0, core_reset}, 32'd1);
      chk($sformatf("v%0d_flush_ready", idx), {31'd0, byte_ready}, 32'd0);
      chk($sformatf("v%0d_flush_done", idx), {31'd0, done}, 32'd0);
      tick();
      chk($sformatf("v%0d_run_corerst", idx), {31'd0, core_reset}, 32'd0);
      chk($sformatf("v%0d_run_done", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_run_ready", idx), {31'd0, byte_ready}, 32'd0);
      chk($sformatf("v%0d_run_wren", idx), {31'd0, imem_wr_en}, 32'd0);
    end
    chk($sformatf("v%0d_nwrites", idx), 32'(cap_data.size()), 32'(v.exp_writes));
    check_words($sformatf("v%0d_words", idx), v.exp_writes);
    if (v.exp_writes > 0 && cap_addr.size() == v.exp_writes) begin
      chk($sformatf("v%0d_last_addr", idx), cap_addr[v.exp_writes-1], 32'(v.exp_writes - 1));
    end
    if (v.reuse) begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < prev_data.size() && i < cap_data.size(); i++)
        if (prev_data[i] !== cap_data[i]) nbad++;
      chk($sformatf("v%0d_same_as_fullrate", idx), 32'(nbad), 32'd0);
    end
    prev_data = cap_data;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    // len, fixed, reuse, gap_max, exp_err, exp_writes
    vecs[0] = '{16'd2,    1'b1, 1'b0, 0, 1'b0, 2};
    vecs[1] = '{16'd0,    1'b0, 1'b0, 0, 1'b1, 0};
    vecs[2] = '{16'd1,    1'b0, 1'b0, 0, 1'b0, 1};
    vecs[3] = '{16'd1025, 1'b0, 1'b0, 0, 1'b1, 0};
    vecs[4] = '{16'd1024, 1'b0, 1'b0, 0, 1'b0, 1024};
    vecs[5] = '{16'd7,    1'b0, 1'b0, 0, 1'b0, 7};
    vecs[6] = '{16'd7,    1'b0, 1'b1, 4, 1'b0, 7};
    vecs[7] = '{16'd3,    1'b0, 1'b0, 2, 1'b0, 3};

    reset_s    = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) tick();
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_wren", {31'd0, imem_wr_en}, 32'd0);
    chk("rst_addr", imem_wr_addr, 32'd0);
    chk("rst_data", imem_wr_data, 32'd0);
    chk("rst_corerst", {31'd0, core_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset_s = 1'b0;
    repeat (2) tick();
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    for (int v = 0; v < NV; v++) begin
      run_vec(vecs[v], v);
      if (v == 0 && cap_data.size() == 2) begin
        chk("tp_word0", cap_data[0], 32'h00000013);
        chk("tp_word1", cap_data[1], 32'hDEADBEEF);
      end
    end

    // Stall mid-word: word 0 complete, 3 bytes of word 1, then silence.
    pulse_start();
    cap_addr.delete();
    cap_data.delete();
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom_range(0, 255)));
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 7; i++) send_byte(payload[i], 0);
    byte_valid = 1'b0;
    repeat (TIMEOUT - 2) tick();
    chk("to_not_yet", {31'd0, err}, 32'd0);
    repeat (3) tick();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_corerst", {31'd0, core_reset}, 32'd1);
    chk("to_ready", {31'd0, byte_ready}, 32'd0);
    chk("to_nwrites", 32'(cap_data.size()), 32'd1);
    check_words("to_words", 1);

    // Recover with a 1-word load, then restart from RUN.
    pulse_start();
    chk("recover_err", {31'd0, err}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 0);
    byte_valid = 1'b0;
    repeat (2) tick();
    chk("recover_done", {31'd0, done}, 32'd1);
    chk("recover_corerst", {31'd0, core_reset}, 32'd0);
    pulse_start();
    chk("rerun_corerst", {31'd0, core_reset}, 32'd1);
    chk("rerun_done", {31'd0, done}, 32'd0);
    chk("rerun_ready", {31'd0, byte_ready}, 32'd1);

    // Loader now in LEN_LO: load 5 words, reset between byte1 and byte2 of word 3.
    cap_addr.delete();
    cap_data.delete();
    payload.delete();
    for (int i = 0; i < 20; i++) payload.push_back(8'($urandom_range(0, 255)));
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 14; i++) send_byte(payload[i], 0);
    byte_valid = 1'b1;
    byte_data  = payload[14];
    reset_s    = 1'b1;
    #1;
    chk("mrst_ready", {31'd0, byte_ready}, 32'd0);
    chk("mrst_wren", {31'd0, imem_wr_en}, 32'd0);
    chk("mrst_addr", imem_wr_addr, 32'd0);
    chk("mrst_data", imem_wr_data, 32'd0);
    chk("mrst_corerst", {31'd0, core_reset}, 32'd1);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    repeat (2) tick();
    reset_s = 1'b0;
    for (int i = 15; i < 20; i++) begin
      byte_data = payload[i];
      tick();
    end
    byte_valid = 1'b0;
    repeat (3) tick();
    chk("mrst_nwrites", 32'(cap_data.size()), 32'd3);
    check_words("mrst_words", 3);
    chk("mrst_idle_ready", {31'd0, byte_ready}, 32'd0);
    chk("mrst_idle_corerst", {31'd0, core_reset}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
